// File: rtl/ctl_ajuste_if.sv
// Signal bundle between the clock mode controller and its neighbours
// (tick divider, button debouncers, the three counter machines, display).
interface ctl_ajuste_if;
  logic       ctla_tick;
  logic       ctla_btn_mode;
  logic       ctla_btn_inc;
  logic       ctla_s_max;
  logic       ctla_m_max;
  logic       ctla_inc_s;
  logic       ctla_inc_m;
  logic       ctla_inc_h;
  logic       ctla_clr_s;
  logic [1:0] ctla_mode;
  logic       ctla_blank_h;
  logic       ctla_blank_m;

  // controller side
  modport master (
    input  ctla_tick, ctla_btn_mode, ctla_btn_inc, ctla_s_max, ctla_m_max,
    output ctla_inc_s, ctla_inc_m, ctla_inc_h, ctla_clr_s, ctla_mode,
    output ctla_blank_h, ctla_blank_m
  );

  // environment side: stimulus sources and counter/display sinks
  modport slave (
    output ctla_tick, ctla_btn_mode, ctla_btn_inc, ctla_s_max, ctla_m_max,
    input  ctla_inc_s, ctla_inc_m, ctla_inc_h, ctla_clr_s, ctla_mode,
    input  ctla_blank_h, ctla_blank_m
  );
endinterface

// File: rtl/ctl_ajuste.sv
// Digital clock mode/sequencing controller: RUN / SET_H / SET_M, carry chain,
// edit blink. Optional edit-mode inactivity timeout under `CTLA_TIMEOUT_EN`.
module ctl_ajuste #(
  parameter int unsigned TIMEOUT_TICKS = 30,
  parameter int unsigned TW            = 5
) (
  input  logic         ctla_clock,
  input  logic         ctla_reset,
  ctl_ajuste_if.master bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   phase, phase_nxt;
  logic   mode_prev, inc_prev;
  logic   mode_press, inc_press;
  logic   inc_s_q, inc_m_q, inc_h_q, clr_s_q;
  logic   inc_s_d, inc_m_d, inc_h_d, clr_s_d;

  if (2**TW <= TIMEOUT_TICKS) begin : g_tw_check
    $error("ctl_ajuste: TW too narrow for TIMEOUT_TICKS");
  end

`ifdef CTLA_TIMEOUT_EN
  logic [TW-1:0] tcnt, tcnt_nxt;
`endif

  assign mode_press = bus.ctla_btn_mode & ~mode_prev;
  assign inc_press  = bus.ctla_btn_inc  & ~inc_prev;

  always_ff @(posedge ctla_clock) begin
    if (!ctla_reset) begin
      state     <= RUN;
      phase     <= 1'b0;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
      inc_s_q   <= 1'b0;
      inc_m_q   <= 1'b0;
      inc_h_q   <= 1'b0;
      clr_s_q   <= 1'b0;
`ifdef CTLA_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      mode_prev <= bus.ctla_btn_mode;
      inc_prev  <= bus.ctla_btn_inc;
      inc_s_q   <= inc_s_d;
      inc_m_q   <= inc_m_d;
      inc_h_q   <= inc_h_d;
      clr_s_q   <= clr_s_d;
`ifdef CTLA_TIMEOUT_EN
      tcnt      <= tcnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    inc_s_d   = 1'b0;
    inc_m_d   = 1'b0;
    inc_h_d   = 1'b0;
    clr_s_d   = 1'b0;
`ifdef CTLA_TIMEOUT_EN
    tcnt_nxt  = tcnt;
`endif

    unique case (state)
      RUN: begin
        // counters wrap from their own values, so the whole carry is one cycle
        if (bus.ctla_tick) begin
          inc_s_d = 1'b1;
          inc_m_d = bus.ctla_s_max;
          inc_h_d = bus.ctla_s_max & bus.ctla_m_max;
        end
        if (mode_press) begin
          state_nxt = SET_H;
          phase_nxt = 1'b0;
        end
      end
      SET_H: begin
        if (mode_press) begin
          state_nxt = SET_M;
          phase_nxt = 1'b0;
        end else begin
          inc_h_d = inc_press;
          if (bus.ctla_tick) phase_nxt = ~phase;
        end
      end
      SET_M: begin
        if (mode_press) begin
          state_nxt = RUN;
          phase_nxt = 1'b0;
          clr_s_d   = 1'b1;
        end else begin
          inc_m_d = inc_press;
          if (bus.ctla_tick) phase_nxt = ~phase;
        end
      end
      default: begin
        state_nxt = RUN;
        phase_nxt = 1'b0;
      end
    endcase

`ifdef CTLA_TIMEOUT_EN
    // any press restarts the idle count and beats a simultaneous expiry
    if (state == RUN || mode_press || inc_press) begin
      tcnt_nxt = '0;
    end else if (bus.ctla_tick) begin
      if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
        state_nxt = RUN;
        phase_nxt = 1'b0;
        clr_s_d   = 1'b1;
        tcnt_nxt  = '0;
      end else begin
        tcnt_nxt = tcnt + 1'b1;
      end
    end
`endif
  end

  assign bus.ctla_inc_s   = inc_s_q;
  assign bus.ctla_inc_m   = inc_m_q;
  assign bus.ctla_inc_h   = inc_h_q;
  assign bus.ctla_clr_s   = clr_s_q;
  assign bus.ctla_mode    = state;
  assign bus.ctla_blank_h = (state == SET_H) & phase;
  assign bus.ctla_blank_m = (state == SET_M) & phase;

endmodule

// File: tb/tb_ctl_ajuste.sv
// Scoreboard bench for ctl_ajuste: a spec-level model pushes the expected
// output word each cycle; the monitor pops and compares after the edge.
module tb_ctl_ajuste;

`ifdef CTLA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int T_TICKS = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ntot = 0;
  int   nbad = 0;
  logic [7:0] sbq[$];
  logic [7:0] obs;
  int   n_s, n_m, n_h, n_c;

  // model state
  int   m_st, m_ph, m_cnt;
  logic m_mprev, m_iprev;

  ctl_ajuste_if bus ();

  ctl_ajuste #(.TIMEOUT_TICKS(T_TICKS), .TW(5)) dut (
    .ctla_clock (clk),
    .ctla_reset (rst),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // output word: {mode[1:0], inc_s, inc_m, inc_h, clr_s, blank_h, blank_m}
  task automatic model_step(output logic [7:0] e);
    logic mp, ip, s, m, h, c;
    int   ns, nph;
    s = 0; m = 0; h = 0; c = 0;
    if (!rst) begin
      m_st = 0; m_ph = 0; m_cnt = 0; m_mprev = 0; m_iprev = 0;
      e = '0;
      return;
    end
    mp = bus.ctla_btn_mode & ~m_mprev;
    ip = bus.ctla_btn_inc & ~m_iprev;
    ns = m_st; nph = m_ph;
    if (m_st == 0) begin
      if (bus.ctla_tick) begin
        s = 1; m = bus.ctla_s_max; h = bus.ctla_s_max & bus.ctla_m_max;
      end
      if (mp) begin ns = 1; nph = 0; end
      m_cnt = 0;
    end else begin
      if (mp) begin
        ns = (m_st == 1) ? 2 : 0;
        c = (m_st == 2);
        nph = 0;
      end else begin
        if (ip) begin
          if (m_st == 1) h = 1; else m = 1;
        end
        if (bus.ctla_tick) nph = 1 - m_ph;
      end
      if (TO_EN) begin
        if (mp || ip) m_cnt = 0;
        else if (bus.ctla_tick) begin
          m_cnt++;
          if (m_cnt == T_TICKS) begin ns = 0; c = 1; nph = 0; m_cnt = 0; end
        end
      end
    end
    m_st = ns; m_ph = nph;
    m_mprev = bus.ctla_btn_mode;
    m_iprev = bus.ctla_btn_inc;
    e = {ns[1:0], s, m, h, c, (ns == 1) && (nph == 1), (ns == 2) && (nph == 1)};
  endtask

  task automatic cyc(input logic t, input logic md, input logic ic,
                     input logic sm = 1'b0, input logic mm = 1'b0);
    logic [7:0] e;
    bus.ctla_tick = t; bus.ctla_btn_mode = md; bus.ctla_btn_inc = ic;
    bus.ctla_s_max = sm; bus.ctla_m_max = mm;
    model_step(e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    obs = {bus.ctla_mode, bus.ctla_inc_s, bus.ctla_inc_m, bus.ctla_inc_h,
           bus.ctla_clr_s, bus.ctla_blank_h, bus.ctla_blank_m};
    chk("cycle", obs, sbq.pop_front());
    n_s += obs[5]; n_m += obs[4]; n_h += obs[3]; n_c += obs[2];
  endtask

  task automatic clr_tally();
    n_s = 0; n_m = 0; n_h = 0; n_c = 0;
  endtask

  initial begin
    bus.ctla_tick = 0; bus.ctla_btn_mode = 0; bus.ctla_btn_inc = 0;
    bus.ctla_s_max = 0; bus.ctla_m_max = 0;
    clr_tally();
    @(posedge clk); #1;

    // reset held with activity on the inputs
    rst = 0;
    cyc(1, 1, 1, 1, 1);
    cyc(1, 0, 0, 1, 1);
    cyc(1, 1, 1, 1, 1);
    chk("rst_out", obs, 8'h00);
    rst = 1;
    cyc(0, 0, 0);
    clr_tally();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    chk("run_inc_s", n_s, 5);
    chk("run_inc_mh", n_m + n_h, 0);

    // carry chain
    cyc(1, 0, 0, 1, 0);
    chk("carry_sm", obs[5:3], 3'b110);
    cyc(0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    chk("carry_smh", obs[5:3], 3'b111);
    cyc(0, 0, 0);

    // hour edit
    cyc(0, 1, 0);
    chk("mode_seth", obs[7:6], 2'b01);
    cyc(0, 0, 0);
    clr_tally();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 10; j++) cyc(0, 0, 1);
      cyc(0, 0, 0);
    end
    chk("seth_inc_h", n_h, 3);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 1, 1);
      chk("blink_h", obs[1], (k % 2 == 0) ? 1 : 0);
      cyc(0, 0, 0);
    end
    chk("seth_no_s", n_s + n_m, 0);

    // minute edit and exit
    cyc(0, 1, 0);
    chk("mode_setm", obs[7:6], 2'b10);
    cyc(0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    chk("setm_inc", obs[4:3], 2'b10);
    cyc(0, 0, 0);
    cyc(1, 1, 0, 1, 1);
    chk("exit_run", {obs[7:6], obs[5], obs[2]}, 4'b0001);
    cyc(0, 0, 0);
    chk("clr_pulse", obs[2], 0);

    // simultaneous mode + inc in SET_H
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    chk("simul_mode", obs[7:6], 2'b10);
    chk("simul_noinc", obs[4:3], 2'b00);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);

    // edit-mode timeout (or persistence without the feature)
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    for (int i = 1; i <= 29; i++) begin cyc(1, 0, 0); cyc(0, 0, 0); end
    chk("to_29", obs[7:6], 2'b01);
    cyc(1, 0, 0);
    chk("to_30_mode", obs[7:6], TO_EN ? 2'b00 : 2'b01);
    chk("to_30_clr", obs[2], TO_EN ? 1'b1 : 1'b0);
    cyc(0, 0, 0);
    if (obs[7:6] != 2'b00) begin cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0); end
    chk("to_back_run", obs[7:6], 2'b00);

    cyc(0, 1, 0);
    cyc(0, 0, 0);
    for (int i = 1; i <= 49; i++) begin
      cyc(1, 0, (i == 20));
      cyc(0, 0, 0);
    end
    chk("to_49", obs[7:6], 2'b01);
    cyc(1, 0, 0);
    chk("to_50_mode", obs[7:6], TO_EN ? 2'b00 : 2'b01);
    cyc(0, 0, 0);
    if (obs[7:6] != 2'b00) begin cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0); end

    // random soak against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end
    rst = 0;
    cyc(1, 1, 1);
    chk("late_rst", obs, 8'h00);
    rst = 1;
    cyc(0, 0, 0);

    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/ctl_ajuste.md
Name: ctl_ajuste

Overview:
- Mode and sequencing controller for the digital clock.
- Converts the 1 Hz tick and two debounced push-buttons into one-cycle increment pulses for the seconds, minutes and hours counter machines.
- Handles the carry chain between the counters.
- Drives blink and blank signals for the display of the field being edited.
- Sits between the button debouncers / tick divider and the three counter machines.

Parameters:
- TIMEOUT_TICKS, 30: number of 1 Hz ticks with no button press before an edit mode returns to RUN (used only with the optional feature).
- TW, 5: width of the timeout tick counter; must satisfy 2^TW > TIMEOUT_TICKS.

Ports:
- ctla_clock  in  1  system clock
- ctla_reset  in  1  synchronous reset, active-low
- ctla_tick  in  1  one-cycle 1 Hz strobe
- ctla_btn_mode  in  1  debounced mode button, level, active-high
- ctla_btn_inc  in  1  debounced increment button, level, active-high
- ctla_s_max  in  1  seconds counter currently holds 59
- ctla_m_max  in  1  minutes counter currently holds 59
- ctla_inc_s  out  1  increment pulse to seconds counter
- ctla_inc_m  out  1  increment pulse to minutes counter
- ctla_inc_h  out  1  increment pulse to hours counter
- ctla_clr_s  out  1  synchronous clear pulse to seconds counter
- ctla_mode  out  2  current state: 00 RUN, 01 SET_H, 10 SET_M
- ctla_blank_h  out  1  blank hour digits
- ctla_blank_m  out  1  blank minute digits

Behaviour:
- Reset: sampled on the rising edge of ctla_clock while ctla_reset = 0.
  - All outputs 0, state RUN, blink phase 0, edge registers 0, timeout counter 0.
- Reset overrides every other event in the same cycle.
- Button handling:
  - Each button has a previous-value register.
  - press = btn & ~btn_prev.
  - Only rising edges act; a held button produces exactly one press.
- All outputs are registered: an input event in cycle N appears on the outputs in cycle N+1.
- Every inc/clr output is a single-cycle pulse.
- State RUN:
  - tick → inc_s = 1.
  - tick & s_max → inc_m = 1 in the same cycle as inc_s.
  - tick & s_max & m_max → inc_h = 1 in the same cycle as inc_s and inc_m.
  - The counters evaluate wrap from their own present values, so all three pulses coincide.
  - ctla_btn_inc press is ignored in RUN.
  - mode press → SET_H.
- State SET_H:
  - No inc_s, and no inc_m / inc_h from ticks; time is frozen.
  - inc press → inc_h = 1; the hours counter performs its own 23→00 wrap.
  - mode press → SET_M.
- State SET_M:
  - No tick-driven pulses.
  - inc press → inc_m = 1 only; the carry to hours is suppressed, even when m_max = 1.
  - mode press → RUN, with clr_s = 1 in the transition cycle so seconds restart at 00.
- Simultaneous mode and inc press in the same cycle:
  - The mode press wins.
  - The inc press is discarded; no increment pulse is issued.
- A tick arriving in the same cycle as a mode press from SET_M to RUN is ignored: no inc_s in that cycle.
- Blink:
  - The phase register toggles on every tick while in SET_H / SET_M.
  - The phase is forced to 0 on entering any state.
  - blank_h = (state == SET_H) & phase.
  - blank_m = (state == SET_M) & phase.
  - Both are 0 in RUN.
- ctla_mode reflects the registered state.

Optional Feature:
- Macro: CTLA_TIMEOUT_EN.
- Defined:
  - In SET_H / SET_M, a counter increments on each tick and clears on any button press.
  - When the counter reaches TIMEOUT_TICKS → state RUN, with clr_s = 1 and the counter cleared.
  - A button press in the same cycle as the timeout takes priority and clears the counter; the state does not exit.
- Undefined:
  - No counter logic is present.
  - Edit modes persist until a mode press.
  - TIMEOUT_TICKS and TW are unused.

Test Plan:
- Reset / hold: hold ctla_reset = 0 for 3 clocks with ticks and presses applied → every output is 0 and mode = 00. Release reset and apply 5 ticks → exactly 5 inc_s pulses, with no inc_m or inc_h.
- Carry chain in RUN: tick with s_max = 1, m_max = 0 → inc_s = inc_m = 1 and inc_h = 0. Tick with s_max = m_max = 1 → inc_s, inc_m and inc_h all pulse in one cycle.
- Hour edit: mode press → mode = 01. Three inc presses, each held for 10 cycles → exactly 3 inc_h pulses. Ticks during SET_H → no inc_s pulses, and blank_h toggles on each tick.
- Minute edit and exit:
  - Second mode press → mode = 10.
  - inc press with m_max = 1 → inc_m = 1 and inc_h = 0.
  - Third mode press → mode = 00 with clr_s = 1 for one cycle.
  - A tick in that same cycle → no inc_s.
- Simultaneous press: mode and inc rise in the same cycle while in SET_H → mode = 10 and no inc_h.
- Timeout (with CTLA_TIMEOUT_EN, TIMEOUT_TICKS = 30): enter SET_H and apply 29 ticks → still mode = 01. 30th tick → mode = 00 and clr_s = 1. Repeat with an inc press at tick 20 → the exit occurs at tick 50.
